alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one Hack ALU between two requesters.
// Grants one requester, registers its operands onto the ALU inputs, captures
// the ALU result and flags on the following edge, and returns them with a
// one-cycle acknowledge to the requester that was granted.
//
// state | meaning
// IDLE  | waiting for req0/req1; ALU inputs hold their last value
// EXEC  | ALU evaluating the registered operands of the granted requester
// RESP  | result registered, ack of the granted requester high for one cycle
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [5:0]       c0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [5:0]       c1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res,
  output logic             res_zr,
  output logic             res_ng,
  output logic             busy,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_c,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             gnt, gnt_nxt;
  logic             last, last_nxt;
  logic             win;
  logic [WIDTH-1:0] alu_x_nxt, alu_y_nxt, res_nxt;
  logic [5:0]       alu_c_nxt;
  logic             res_zr_nxt, res_ng_nxt;
  logic             ack0_nxt, ack1_nxt;

  // Winner is 1 when requester 1 wins: sole requester wins, ties go to !last.
  assign win  = req1 & (~req0 | ~last);
  assign busy = (state == EXEC) || (state == RESP);

  // State, grant history and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      alu_x  <= '0;
      alu_y  <= '0;
      alu_c  <= '0;
      res    <= '0;
      res_zr <= 1'b0;
      res_ng <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      last   <= last_nxt;
      alu_x  <= alu_x_nxt;
      alu_y  <= alu_y_nxt;
      alu_c  <= alu_c_nxt;
      res    <= res_nxt;
      res_zr <= res_zr_nxt;
      res_ng <= res_ng_nxt;
      ack0   <= ack0_nxt;
      ack1   <= ack1_nxt;
    end
  end

  // Next-state and next-datapath logic; everything holds unless the state acts on it.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    last_nxt   = last;
    alu_x_nxt  = alu_x;
    alu_y_nxt  = alu_y;
    alu_c_nxt  = alu_c;
    res_nxt    = res;
    res_zr_nxt = res_zr;
    res_ng_nxt = res_ng;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nxt   = win;
          last_nxt  = win;
          alu_x_nxt = win ? x1 : x0;
          alu_y_nxt = win ? y1 : y0;
          alu_c_nxt = win ? c1 : c0;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        res_nxt    = alu_out;
        res_zr_nxt = alu_zr;
        res_ng_nxt = alu_ng;
        ack0_nxt   = ~gnt;
        ack1_nxt   = gnt;
        state_nxt  = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural Hack ALU on the alu_* port.
// Stimulus pushes expected responses into a scoreboard; a monitor pops and
// compares whenever an ack is presented.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] x0, y0, x1, y1;
  logic [5:0]  c0, c1;
  logic        ack0, ack1;
  logic [15:0] res;
  logic        res_zr, res_ng, busy;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_c;
  logic        alu_zr, alu_ng;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        zr;
    logic        ng;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .x0(x0), .y0(y0), .c0(c0),
    .req1(req1), .x1(x1), .y1(y1), .c1(c1),
    .ack0(ack0), .ack1(ack1),
    .res(res), .res_zr(res_zr), .res_ng(res_ng), .busy(busy),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hack ALU reference: returns {zr, ng, out}.
  function automatic logic [17:0] hack(input logic [15:0] x, input logic [15:0] y,
                                       input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    o = c[1] ? (a + b) : (a & b);
    if (c[0]) o = ~o;
    return {(o == 16'h0000), o[15], o};
  endfunction

  always_comb {alu_zr, alu_ng, alu_out} = hack(alu_x, alu_y, alu_c);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (ack0 || ack1)) begin
      exp_t e;
      chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_id", {31'd0, ack1}, e.id);
        chk("res", {16'd0, res}, {16'd0, e.res});
        chk("res_zr", {31'd0, res_zr}, {31'd0, e.zr});
        chk("res_ng", {31'd0, res_ng}, {31'd0, e.ng});
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  // Single request from one requester, held until its ack; returns in IDLE.
  task automatic single(input int id, input logic [15:0] x, input logic [15:0] y,
                        input logic [5:0] c, input logic [15:0] er,
                        input logic ez, input logic eg);
    if (id == 0) begin
      x0 = x; y0 = y; c0 = c; req0 = 1'b1;
    end else begin
      x1 = x; y1 = y; c1 = c; req1 = 1'b1;
    end
    sb.push_back('{id, er, ez, eg, cyc + 2});
    repeat (2) @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    x0 = '0; y0 = '0; c0 = '0;
    x1 = '0; y1 = '0; c1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_res", {13'd0, res_zr, res_ng, busy, res}, 32'd0);
    chk("rst_alu_xy", {alu_x, alu_y}, 32'd0);
    chk("rst_alu_c", {26'd0, alu_c}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Requester 0 alone: 5 + 3.
    single(0, 16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
    // Requester 1 alone: constant 0, then constant -1.
    single(1, 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
    single(1, 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);

    // Both requesting out of reset and held: grants 0,1,0.
    rst_n = 1'b0;
    x0 = 16'h00F0; y0 = 16'h0FF0; c0 = 6'b000000;
    x1 = 16'd7;    y1 = 16'd9;    c1 = 6'b000010;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = cyc;
    sb.push_back('{0, 16'h00F0, 1'b0, 1'b0, k + 2});
    sb.push_back('{1, 16'd16,   1'b0, 1'b0, k + 5});
    sb.push_back('{0, 16'h00F0, 1'b0, 1'b0, k + 8});
    repeat (8) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;

    // Request dropped after grant, operands changed: original operands used.
    x0 = 16'd10; y0 = 16'd20; c0 = 6'b000010; req0 = 1'b1;
    sb.push_back('{0, 16'd30, 1'b0, 1'b0, cyc + 2});
    @(posedge clk);
    #1;
    req0 = 1'b0; x0 = 16'd99; y0 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_busy_idle", {31'd0, busy}, 32'd0);
    chk("drop_alu_hold", {alu_x, alu_y}, {16'd10, 16'd20});

    // Reset during EXEC of a requester-0 operation: aborted, no ack.
    x0 = 16'd1; y0 = 16'd1; c0 = 6'b000010; req0 = 1'b1;
    @(posedge clk);
    #1;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ack_busy", {29'd0, busy, ack1, ack0}, 32'd0);
    chk("abort_res", {14'd0, res_zr, res_ng, res}, 32'd0);
    chk("abort_alu", {alu_x, alu_y}, 32'd0);
    chk("abort_alu_c", {26'd0, alu_c}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Tie right after reset: requester 0 must win again.
    x0 = 16'd3; y0 = 16'd4; c0 = 6'b000010;
    x1 = 16'd0; y1 = 16'd0; c1 = 6'b101010;
    req0 = 1'b1; req1 = 1'b1;
    k = cyc;
    sb.push_back('{0, 16'd7, 1'b0, 1'b0, k + 2});
    sb.push_back('{1, 16'd0, 1'b1, 1'b0, k + 5});
    repeat (5) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
